// File: rtl/payload_byte_scheduler.sv
// Serialises BW*N_PRL sample groups into BW_OUT-bit bytes, PKT_GROUPS groups per packet; first byte 1 cycle after accept.
// Output holds while !m_ready and s_ready drops until the last byte leaves; define SEQ_HEADER_EN for a 4-byte sequence header.
module payload_byte_scheduler #(
  parameter int BW         = 18,
  parameter int N_PRL      = 4,
  parameter int BW_OUT     = 8,
  parameter int PKT_GROUPS = 16
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              enable,
  input  logic [BW-1:0]     s_data [N_PRL],
  input  logic              s_valid,
  output logic              s_ready,
  output logic [BW_OUT-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);

  localparam int W      = BW * N_PRL;
  localparam int NBYTES = W / BW_OUT;
  localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GW     = (PKT_GROUPS > 1) ? $clog2(PKT_GROUPS) : 1;
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);
  localparam logic [GW-1:0]  LAST_GRP  = GW'(PKT_GROUPS - 1);

  generate
    if ((W % BW_OUT) != 0 || PKT_GROUPS < 1) begin : g_bad_cfg
      $error("payload_byte_scheduler: BW*N_PRL must be a multiple of BW_OUT and PKT_GROUPS must be >= 1");
    end
`ifdef SEQ_HEADER_EN
    if (BW_OUT != 8) begin : g_bad_hdr
      $error("payload_byte_scheduler: the sequence header needs BW_OUT == 8");
    end
`endif
  endgenerate

`ifdef SEQ_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HDR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   word_q, word_d, word_in;
  logic [BIW-1:0] byte_q, byte_d;
  logic [GW-1:0]  grp_q, grp_d, grp_inc, nxt_grp;
  logic           last_byte, slot_free, accept;
`ifdef SEQ_HEADER_EN
  logic [31:0]    seq_q, seq_d, seq_nxt;
  logic [31:0]    hdr_q, hdr_d;
  logic [1:0]     hidx_q, hidx_d;
`endif

  always_comb begin
    word_in = '0;
    for (int i = 0; i < N_PRL; i++) begin
      word_in[W-1-BW*i -: BW] = s_data[i];
    end
  end

  // nxt_grp is the index the next accepted group will get; 0 means it opens a packet
  assign grp_inc   = (grp_q == LAST_GRP) ? '0 : grp_q + 1'b1;
  assign nxt_grp   = (state_q == IDLE) ? grp_q : grp_inc;
  assign last_byte = (state_q == SHIFT) && (byte_q == LAST_BYTE);
  assign slot_free = (state_q == IDLE) || (last_byte && m_ready);
  assign s_ready   = srst_n && slot_free && ((nxt_grp != '0) || enable);
  assign accept    = s_valid && s_ready;
  assign m_valid   = (state_q != IDLE);
  assign m_last    = last_byte && (grp_q == LAST_GRP);
  assign busy      = (state_q != IDLE) || (grp_q != '0);

  always_comb begin
    m_data = '0;
    if (state_q == SHIFT) begin
      m_data = word_q[W-1 -: BW_OUT];
    end
`ifdef SEQ_HEADER_EN
    else if (state_q == HDR) begin
      m_data = hdr_q[31 -: BW_OUT];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    grp_d   = grp_q;
`ifdef SEQ_HEADER_EN
    seq_nxt = seq_q + {31'd0, (m_last && m_ready)};
    seq_d   = seq_nxt;
    hdr_d   = hdr_q;
    hidx_d  = hidx_q;
`endif
    case (state_q)
      SHIFT: begin
        if (m_ready) begin
          if (byte_q == LAST_BYTE) begin
            grp_d   = grp_inc;
            state_d = IDLE;
          end else begin
            byte_d = byte_q + 1'b1;
            word_d = word_q << BW_OUT;
          end
        end
      end
`ifdef SEQ_HEADER_EN
      HDR: begin
        if (m_ready) begin
          hdr_d  = hdr_q << 8;
          hidx_d = hidx_q + 1'b1;
          if (hidx_q == 2'd3) begin
            state_d = SHIFT;
          end
        end
      end
`endif
      default: ;
    endcase
    // accept only fires from IDLE or on the final byte handshake, so it overrides the above
    if (accept) begin
      word_d  = word_in;
      byte_d  = '0;
      state_d = SHIFT;
`ifdef SEQ_HEADER_EN
      if (nxt_grp == '0) begin
        state_d = HDR;
        hdr_d   = seq_nxt;
        hidx_d  = 2'd0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      grp_q   <= '0;
`ifdef SEQ_HEADER_EN
      seq_q   <= '0;
      hdr_q   <= '0;
      hidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      grp_q   <= grp_d;
`ifdef SEQ_HEADER_EN
      seq_q   <= seq_d;
      hdr_q   <= hdr_d;
      hidx_q  <= hidx_d;
`endif
    end
  end

endmodule

// File: tb/tb_payload_byte_scheduler.sv
// Scoreboard bench for payload_byte_scheduler: accepted groups expand into expected bytes, a negedge monitor compares.
module tb_payload_byte_scheduler;

  localparam int BW         = 18;
  localparam int N_PRL      = 4;
  localparam int BW_OUT     = 8;
  localparam int PKT_GROUPS = 2;
  localparam int NB         = BW * N_PRL / BW_OUT;

  logic              clk = 1'b0;
  logic              srst_n, enable, s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [BW-1:0]     s_data [N_PRL];
  logic [BW_OUT-1:0] m_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BW_OUT-1:0] d;
    logic              last;
  } exp_t;

  exp_t        q[$];
  int          grp_m = 0;
  logic [31:0] seq_m = '0;

  always #5 clk = ~clk;

  payload_byte_scheduler #(
    .BW(BW), .N_PRL(N_PRL), .BW_OUT(BW_OUT), .PKT_GROUPS(PKT_GROUPS)
  ) dut (
    .clk(clk), .srst_n(srst_n), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
  endtask

  // Reference: a packet is PKT_GROUPS groups; each group is its samples concatenated MSB-first,
  // cut into NB bytes from the top; the optional header carries the packet sequence number.
  task automatic push_group();
    logic [BW*N_PRL-1:0] w;
    exp_t e;
    w = '0;
    for (int i = 0; i < N_PRL; i++) w = (w << BW) | (BW*N_PRL)'(s_data[i]);
`ifdef SEQ_HEADER_EN
    if (grp_m == 0) begin
      for (int k = 0; k < 4; k++) begin
        e.d = BW_OUT'(seq_m >> (8 * (3 - k)));
        e.last = 1'b0;
        q.push_back(e);
      end
    end
`endif
    for (int j = 0; j < NB; j++) begin
      e.d = BW_OUT'(w >> (BW_OUT * (NB - 1 - j)));
      e.last = (j == NB - 1) && (grp_m == PKT_GROUPS - 1);
      q.push_back(e);
    end
    grp_m = (grp_m + 1) % PKT_GROUPS;
  endtask

  always @(negedge clk) begin
    logic exp_rdy;
    exp_t e;
    if (!srst_n) begin
      chk_reset_outputs();
      q.delete();
      grp_m = 0;
      seq_m = '0;
    end else begin
      exp_rdy = ((q.size() == 0) || (q.size() == 1 && m_ready)) && ((grp_m != 0) || enable);
      chk("s_ready", s_ready, exp_rdy);
      chk("busy", busy, (q.size() != 0) || (grp_m != 0));
      chk("m_valid", m_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_data", m_data, q[0].d);
        chk("m_last", m_last, q[0].last);
        if (m_ready) begin
          e = q.pop_front();
          if (e.last) seq_m = seq_m + 1;
        end
      end
      if (s_valid && exp_rdy) push_group();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N_PRL; i++) s_data[i] = BW'($urandom);
  endtask

  initial begin
    srst_n  = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < N_PRL; i++) s_data[i] = '0;
    repeat (3) step();
    srst_n = 1'b1;

    // single group 3FFFF,0,0,0 with an always-ready sink
    enable    = 1'b1;
    m_ready   = 1'b1;
    s_data[0] = 18'h3FFFF;
    s_valid   = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (12) step();

    // sink stalls for 5 cycles while byte 3 is presented
    rand_data();
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (3) step();
    m_ready = 1'b0;
    repeat (5) step();
    m_ready = 1'b1;
    repeat (10) step();

    // source and sink held ready: a full packet streams back-to-back
    for (int c = 0; c < 18; c++) begin
      rand_data();
      s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    repeat (12) step();

    // enable drops after the first group: packet still completes, next one is held off
    rand_data();
    s_valid = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 25; c++) begin
      rand_data();
      step();
    end
    s_valid = 1'b0;
    enable  = 1'b1;
    step();

    // reset while byte 5 is on the output, then a fresh packet
    rand_data();
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (5) step();
    srst_n = 1'b0;
    #1;
    chk_reset_outputs();
    step();
    srst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      rand_data();
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      repeat (12) step();
    end

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rand_data();
      s_valid = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        srst_n = 1'b0;
        #1;
        chk_reset_outputs();
        step();
        srst_n = 1'b1;
      end
      step();
    end

    s_valid = 1'b0;
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int c = 0; c < 200 && q.size() != 0; c++) step();
    chk("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/payload_byte_scheduler.md
PAYLOAD_BYTE_SCHEDULER -- requirements
Module: payload_byte_scheduler

Interface
REQ-001 Parameter BW, default 18: bits per parallel sample.
REQ-002 Parameter N_PRL, default 4: samples per input group.
REQ-003 Parameter BW_OUT, default 8: output byte width.
REQ-004 Parameter PKT_GROUPS, default 16: input groups per UDP payload packet.
REQ-005 Derived NBYTES = BW*N_PRL/BW_OUT; elaboration SHALL fail if BW*N_PRL is not a multiple of BW_OUT or PKT_GROUPS < 1.
REQ-006 clk  in  1  clock; all logic rising-edge.
REQ-007 srst_n  in  1  reset, asynchronous, active-low.
REQ-008 enable  in  1  permits a new packet to start.
REQ-009 s_data  in  BW x [N_PRL]  sample group; s_data[0] is most significant.
REQ-010 s_valid  in  1  s_data valid.
REQ-011 s_ready  out  1  group accepted when s_valid && s_ready.
REQ-012 m_data  out  BW_OUT  payload byte.
REQ-013 m_valid  out  1  m_data valid.
REQ-014 m_ready  in  1  byte consumed when m_valid && m_ready.
REQ-015 m_last  out  1  final byte of packet, qualified by m_valid.
REQ-016 busy  out  1  high when state != IDLE or a packet is partially sent.

Function
REQ-017 States SHALL be IDLE, HDR (present only with SEQ_HEADER_EN), SHIFT.
REQ-018 On acceptance, group SHALL be registered as a BW*N_PRL word: s_data[i] at bits [BW*(N_PRL-i)-1 -: BW].
REQ-019 Byte j (j=0 first) of a group SHALL be word bits [BW_OUT*(NBYTES-1-j) +: BW_OUT].
REQ-020 First byte m_valid SHALL assert the cycle after acceptance (latency 1).
REQ-021 While m_valid && !m_ready, m_data, m_last and m_valid SHALL hold stable.
REQ-022 Byte index SHALL advance only on m_valid && m_ready; no bubbles while m_ready=1.
REQ-023 s_ready SHALL be 1 in IDLE, and in SHIFT only when byte index = NBYTES-1 and m_ready=1 (back-to-back, no gap cycle); otherwise 0.
REQ-024 When group counter = 0 (packet boundary), s_ready SHALL additionally require enable=1.
REQ-025 Group counter SHALL increment after the last byte of each group is consumed and wrap PKT_GROUPS-1 -> 0.
REQ-026 m_last SHALL be 1 only on byte NBYTES-1 of group PKT_GROUPS-1.
REQ-027 enable deasserted mid-packet SHALL NOT stop the packet; it takes effect only at the next boundary.
REQ-028 SHIFT with last byte consumed and no new acceptance SHALL return to IDLE; m_valid 0 next cycle.
REQ-029 s_valid SHALL be ignored while s_ready=0; no input is dropped or duplicated.

Reset
REQ-030 srst_n low SHALL immediately force state IDLE, byte index 0, group counter 0, sequence counter 0.
REQ-031 During and after reset: m_valid=0, m_last=0, m_data=0, busy=0; s_ready=0 while srst_n=0.
REQ-032 Reset mid-packet SHALL discard the partial packet; next accepted group starts a new packet.

Configuration
REQ-033 Macro SEQ_HEADER_EN: when defined, each packet SHALL be preceded by 4 header bytes: a 32-bit sequence counter, MSB first.
REQ-034 With SEQ_HEADER_EN, acceptance at group counter 0 SHALL enter HDR, emit 4 bytes under the same handshake, then SHIFT; sequence counter increments on m_last handshake, wraps 2^32-1 -> 0; m_last never on a header byte.
REQ-035 Without SEQ_HEADER_EN, HDR and the sequence counter SHALL not exist; payload bytes only.

Verification (BW=18, N_PRL=4, BW_OUT=8, NBYTES=9)
REQ-036 s_data={3FFFF,0,0,0}, m_ready=1 -> bytes FF FF C0 00 00 00 00 00 00 on consecutive cycles, first one cycle after acceptance.
REQ-037 m_ready low 5 cycles at byte 3 -> m_data/m_valid stable all 5 cycles; resumes with byte 4, no loss.
REQ-038 PKT_GROUPS=2, s_valid and m_ready held 1 -> 18 bytes in 18 consecutive cycles, m_last only on byte 18, s_ready pulses on bytes 9 and 18.
REQ-039 enable dropped after first group of 2-group packet -> second group accepted, packet ends with m_last, then s_ready=0 and busy=0.
REQ-040 SEQ_HEADER_EN, two packets -> headers 00 00 00 00 then 00 00 00 01, each followed by data bytes.
REQ-041 srst_n pulsed low at byte 5 -> m_valid=0 immediately; next group restarts at byte 0, group 0 (header 00 00 00 00 if enabled).
